// File: rtl/key_filter_multi.sv
// N-channel debouncer for active-low keys: 2-flop synchroniser, 4-state filter FSM, level + pulse outputs.
// Optional long-hold pulse on key_long is compiled in with `define LONG_PRESS_EN.
module key_filter_multi #(
    parameter int CHANNELS  = 4,
    parameter int MASK_TIME = 500000,
    parameter int LONG_TIME = 50000000,
    parameter int CNT_W     = 26
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] key_in,
    output logic [CHANNELS-1:0] key_out,
    output logic [CHANNELS-1:0] key_press,
    output logic [CHANNELS-1:0] key_release,
    output logic [CHANNELS-1:0] key_long
);

    typedef enum logic [1:0] {IDLE, PRESS_FLT, PRESSED, REL_FLT} state_t;

    localparam logic [CNT_W-1:0] MASK_LAST = CNT_W'(MASK_TIME - 1);
`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_TIME);
`endif

    // The counter must hold both terminal values without wrapping.
    if (MASK_TIME < 2 || (64'd1 << CNT_W) <= 64'(MASK_TIME) || (64'd1 << CNT_W) <= 64'(LONG_TIME)) begin : g_bad_params
        $error("key_filter_multi: MASK_TIME < 2 or CNT_W too narrow");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             sync1, sync2;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             out_q, out_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
`ifdef LONG_PRESS_EN
        logic             long_q, long_d;
`endif

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1   <= 1'b1;
                sync2   <= 1'b1;
                state_q <= IDLE;
                cnt_q   <= '0;
                out_q   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
`ifdef LONG_PRESS_EN
                long_q  <= 1'b0;
`endif
            end else begin
                sync1   <= key_in[i];
                sync2   <= sync1;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                press_q <= press_d;
                rel_q   <= rel_d;
`ifdef LONG_PRESS_EN
                long_q  <= long_d;
`endif
            end
        end

        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (!sync2) begin
                        state_d = PRESS_FLT;
                        cnt_d   = '0;
                    end
                end
                PRESS_FLT: begin
                    if (sync2) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == MASK_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (sync2) begin
                        state_d = REL_FLT;
                        cnt_d   = '0;
                    end
`ifdef LONG_PRESS_EN
                    // Counts past LONG_LAST once, then parks so key_long cannot repeat.
                    else if (cnt_q != LONG_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
                REL_FLT: begin
                    if (!sync2) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == MASK_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            out_d   = out_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
`ifdef LONG_PRESS_EN
            long_d  = 1'b0;
`endif
            case (state_q)
                PRESS_FLT: begin
                    if (!sync2 && cnt_q == MASK_LAST) begin
                        out_d   = 1'b0;
                        press_d = 1'b1;
                    end
                end
                REL_FLT: begin
                    if (sync2 && cnt_q == MASK_LAST) begin
                        out_d = 1'b1;
                        rel_d = 1'b1;
                    end
                end
`ifdef LONG_PRESS_EN
                PRESSED: begin
                    if (!sync2 && cnt_q == LONG_LAST) begin
                        long_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end

        assign key_out[i]     = out_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
`ifdef LONG_PRESS_EN
        assign key_long[i]    = long_q;
`else
        assign key_long[i]    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Scoreboard bench for key_filter_multi: stimulus queues expected pulses (kind, channel, cycle),
// a negedge monitor pops and compares each pulse the DUT emits.
module tb_key_filter_multi;

    localparam int CH    = 2;
    localparam int MASK  = 25;
    localparam int LONG  = 100;
    localparam int LAT   = MASK + 3;   // negedge-of-drive to negedge-after-output-edge

    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_LONG    = 3;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] key_in;
    logic [CH-1:0] key_out;
    logic [CH-1:0] key_press;
    logic [CH-1:0] key_release;
    logic [CH-1:0] key_long;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    key_filter_multi #(
        .CHANNELS (CH),
        .MASK_TIME(MASK),
        .LONG_TIME(LONG),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int ch, input int at);
        exp_t e;
        e.code = kind * 16 + ch;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Drive one channel at a negedge and return the cycle stamp of that drive.
    task automatic set_key(input int ch, input logic v, output int t);
        @(negedge clk);
        key_in[ch] = v;
        t = cyc;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every asserted pulse bit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int ch = 0; ch < CH; ch++) begin
                for (int k = K_PRESS; k <= K_LONG; k++) begin
                    logic hit;
                    int   code;
                    exp_t e;
                    hit  = (k == K_PRESS) ? key_press[ch] : (k == K_RELEASE) ? key_release[ch] : key_long[ch];
                    code = k * 16 + ch;
                    if (hit) begin
                        if (exp_q.size() == 0) begin
                            check("spurious pulse code", code, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("pulse code", code, e.code);
                            check("pulse cycle", cyc, e.cyc);
                            if (k == K_PRESS)   check("level at press", int'(key_out[ch]), 0);
                            if (k == K_RELEASE) check("level at release", int'(key_out[ch]), 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int t;
        int t2;

        // 1: reset with keys idle
        rst_n  = 1'b0;
        key_in = 2'b11;
        #1000;
        check("key_out in reset", int'(key_out), 3);
        check("pulses in reset", int'({key_press, key_release, key_long}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(40);
        check("key_out after reset", int'(key_out), 3);

        // 2: ch0 press with 2/1/10/2 cycle bounce, then held low
        set_key(0, 1'b0, t); wait_cyc(1);
        set_key(0, 1'b1, t); wait_cyc(0);
        set_key(0, 1'b0, t); wait_cyc(9);
        set_key(0, 1'b1, t); wait_cyc(1);
        set_key(0, 1'b0, t);
        push(K_PRESS, 0, t + LAT);
        wait_cyc(26);
        check("ch0 not yet pressed", int'(key_out), 3);
        wait_cyc(74);
        check("ch0 pressed, ch1 idle", int'(key_out), 2);

        // 3: ch0 release with sub-mask bounce
        set_key(0, 1'b1, t); wait_cyc(4);
        set_key(0, 1'b0, t); wait_cyc(2);
        set_key(0, 1'b1, t); wait_cyc(19);
        set_key(0, 1'b0, t);
        set_key(0, 1'b1, t);
        push(K_RELEASE, 0, t + LAT);
        wait_cyc(60);
        check("ch0 released", int'(key_out), 3);

        // 4: simultaneous press, staggered release
        @(negedge clk);
        key_in = 2'b00;
        t = cyc;
        push(K_PRESS, 0, t + LAT);
        push(K_PRESS, 1, t + LAT);
        wait_cyc(40);
        check("both pressed", int'(key_out), 0);
        set_key(0, 1'b1, t);
        push(K_RELEASE, 0, t + LAT);
        wait_cyc(9);
        set_key(1, 1'b1, t2);
        push(K_RELEASE, 1, t2 + LAT);
        check("release stagger", t2 - t, 10);
        wait_cyc(60);
        check("both released", int'(key_out), 3);

        // 5: ch1 long hold
        set_key(1, 1'b0, t);
        push(K_PRESS, 1, t + LAT);
`ifdef LONG_PRESS_EN
        push(K_LONG, 1, t + LAT + LONG);
`endif
        wait_cyc(LAT + 200);
        check("ch1 held", int'(key_out), 1);
        set_key(1, 1'b1, t);
        push(K_RELEASE, 1, t + LAT);
        wait_cyc(60);

        // 6: reset in the middle of PRESS_FLT with the key still low
        set_key(0, 1'b0, t);
        wait_cyc(14);
        rst_n = 1'b0;
        wait_cyc(5);
        check("key_out in mid reset", int'(key_out), 3);
        check("pulses in mid reset", int'({key_press, key_release, key_long}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        t = cyc;
        push(K_PRESS, 0, t + LAT);
        wait_cyc(60);
        check("ch0 pressed after reset", int'(key_out), 2);
        set_key(0, 1'b1, t);
        push(K_RELEASE, 0, t + LAT);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        wait_cyc(10);
        check("final key_out", int'(key_out), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
